// File: rtl/sap_pkg.sv
// Shared SAP-1 encodings: opcodes, one-hot T-states and control-word bit indices.
package sap_pkg;

    localparam int unsigned NUM_T = 6;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned CW_W  = 12;

    localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    localparam logic [NUM_T-1:0] T1 = 6'b000001;
    localparam logic [NUM_T-1:0] T2 = 6'b000010;
    localparam logic [NUM_T-1:0] T3 = 6'b000100;
    localparam logic [NUM_T-1:0] T4 = 6'b001000;
    localparam logic [NUM_T-1:0] T5 = 6'b010000;
    localparam logic [NUM_T-1:0] T6 = 6'b100000;

    typedef enum logic [3:0] {
        CW_CP = 4'd0,
        CW_EP = 4'd1,
        CW_LM = 4'd2,
        CW_CE = 4'd3,
        CW_LI = 4'd4,
        CW_EI = 4'd5,
        CW_LA = 4'd6,
        CW_EA = 4'd7,
        CW_SU = 4'd8,
        CW_EU = 4'd9,
        CW_LB = 4'd10,
        CW_LO = 4'd11
    } cw_bit_e;

    typedef logic [CW_W-1:0] ctrl_word_t;

    function automatic logic is_onehot(input logic [NUM_T-1:0] v);
        return (v != '0) && ((v & (v - NUM_T'(1))) == '0);
    endfunction

endpackage

// File: rtl/sap_controller_sequencer_if.sv
// Controller-to-datapath bundle: step enable, opcode in; T-state, halt and strobes out.
interface sap_controller_sequencer_if;
    import sap_pkg::*;

    logic              run;
    logic [OP_W-1:0]   opcode;
    logic [NUM_T-1:0]  tstate;
    logic              halted;
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;

    modport master (
        input  run, opcode,
        output tstate, halted, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo
    );

    modport slave (
        output run, opcode,
        input  tstate, halted, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo
    );

endinterface

// File: rtl/sap_ring_counter.sv
// One-hot T-state ring: rotates when advancing, early return to T1, illegal states recover to T1.
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic             clk,
    input  logic             clear_n,
    input  logic             advance,
    input  logic             early_return,
    output logic [NUM_T-1:0] tstate
);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            tstate <= T1;
        end else if (advance) begin
            if (!is_onehot(tstate) || early_return) begin
                tstate <= T1;
            end else begin
                tstate <= {tstate[NUM_T-2:0], tstate[NUM_T-1]};
            end
        end
    end

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP-1 control unit: T-state ring plus control-word decoder and HLT latch.
// Define SAP_VARIABLE_CYCLE_EN to end each instruction after its last active execute state.
module sap_controller_sequencer
    import sap_pkg::*;
(
    input  logic                          clk,
    input  logic                          clear_n,
    sap_controller_sequencer_if.master    bus
);

    logic [NUM_T-1:0] tstate;
    logic             halted_q;
    logic             active_c;
    logic             halt_now_c;
    logic             advance_c;
    logic             early_c;
    ctrl_word_t       cw_c;

    assign active_c   = clear_n && bus.run && !halted_q;
    assign halt_now_c = active_c && (tstate == T4) && (bus.opcode == OP_HLT);
    // HLT freezes the ring at T4 on the same edge it sets halted
    assign advance_c  = bus.run && !halted_q && !halt_now_c;

`ifdef SAP_VARIABLE_CYCLE_EN
    assign early_c = ((tstate == T5) && (bus.opcode == OP_LDA)) ||
                     ((tstate == T4) && !(bus.opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_HLT}));
`else
    assign early_c = 1'b0;
`endif

    sap_ring_counter u_ring (
        .clk          (clk),
        .clear_n      (clear_n),
        .advance      (advance_c),
        .early_return (early_c),
        .tstate       (tstate)
    );

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            halted_q <= 1'b0;
        end else if (halt_now_c) begin
            halted_q <= 1'b1;
        end
    end

    // Control-word decode from registered T-state and IR opcode
    always_comb begin
        cw_c = '0;
        if (active_c) begin
            case (tstate)
                T1: begin cw_c[CW_EP] = 1'b1; cw_c[CW_LM] = 1'b1; end
                T2: cw_c[CW_CP] = 1'b1;
                T3: begin cw_c[CW_CE] = 1'b1; cw_c[CW_LI] = 1'b1; end
                T4: begin
                    if (bus.opcode inside {OP_LDA, OP_ADD, OP_SUB}) begin
                        cw_c[CW_EI] = 1'b1;
                        cw_c[CW_LM] = 1'b1;
                    end else if (bus.opcode == OP_OUT) begin
                        cw_c[CW_EA] = 1'b1;
                        cw_c[CW_LO] = 1'b1;
                    end
                end
                T5: begin
                    if (bus.opcode == OP_LDA) begin
                        cw_c[CW_CE] = 1'b1;
                        cw_c[CW_LA] = 1'b1;
                    end else if (bus.opcode inside {OP_ADD, OP_SUB}) begin
                        cw_c[CW_CE] = 1'b1;
                        cw_c[CW_LB] = 1'b1;
                    end
                end
                T6: begin
                    if (bus.opcode inside {OP_ADD, OP_SUB}) begin
                        cw_c[CW_EU] = 1'b1;
                        cw_c[CW_LA] = 1'b1;
                        cw_c[CW_SU] = (bus.opcode == OP_SUB);
                    end
                end
                default: cw_c = '0;
            endcase
        end
    end

    assign bus.tstate = tstate;
    assign bus.halted = halted_q;
    assign bus.cp     = cw_c[CW_CP];
    assign bus.ep     = cw_c[CW_EP];
    assign bus.lm     = cw_c[CW_LM];
    assign bus.ce     = cw_c[CW_CE];
    assign bus.li     = cw_c[CW_LI];
    assign bus.ei     = cw_c[CW_EI];
    assign bus.la     = cw_c[CW_LA];
    assign bus.ea     = cw_c[CW_EA];
    assign bus.su     = cw_c[CW_SU];
    assign bus.eu     = cw_c[CW_EU];
    assign bus.lb     = cw_c[CW_LB];
    assign bus.lo     = cw_c[CW_LO];

endmodule
